// File: rtl/addsub_pkg.sv
// ============================================================================
// Module      : addsub_pkg
// Description : Shared opcodes, FSM state type and slice-count helper for addsub_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int num_slices(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cla_slice.sv
// ============================================================================
// Module      : cla_slice
// Description : CHUNK-bit combinational carry-lookahead adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic [CHUNK-1:0] w_g;
   logic [CHUNK-1:0] w_p;
   logic [CHUNK:0]   w_c;
   logic             w_cur;
   logic             w_pp;

   assign w_g = x & y;
   assign w_p = x ^ y;

   // Each carry is the flat sum-of-products of generates and propagates,
   // so no carry depends on the previous carry signal.
   always_comb begin
      w_c    = '0;
      w_cur  = 1'b0;
      w_pp   = 1'b0;
      w_c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         w_cur = w_g[i];
         w_pp  = w_p[i];
         for (int j = i - 1; j >= 0; j--) begin
            w_cur = w_cur | (w_pp & w_g[j]);
            w_pp  = w_pp & w_p[j];
         end
         w_c[i+1] = w_cur | (w_pp & cin);
      end
   end

   assign s    = w_p ^ w_c[CHUNK-1:0];
   assign cout = w_c[CHUNK];

endmodule

`default_nettype wire

// File: rtl/addsub_seq.sv
// ============================================================================
// Module      : addsub_seq
// Description : Multi-cycle add/sub, one CHUNK-bit slice per clock, with flags.
//               Optional signed saturation enabled by defining ADDSUB_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_seq
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf,
   output logic             zero,
   output logic             neg,
   output logic             illegal
);

   localparam int N_SLICES = num_slices(WIDTH, CHUNK);
   localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICES - 1);
`ifdef ADDSUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   generate
      if (WIDTH % CHUNK != 0) begin : g_width_check
         $error("addsub_seq: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;        // already inverted for SUB
   logic             cy_q, cy_d;      // inter-slice carry
   logic             ill_q, ill_d;    // captured opcode was illegal
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             illegal_q, illegal_d;

   logic [CHUNK-1:0] w_x;
   logic [CHUNK-1:0] w_y;
   logic [CHUNK-1:0] w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_res_full;
   logic [WIDTH-1:0] w_res_sat;
   logic             w_ovf;

   assign w_x = a_q[int'(cnt_q)*CHUNK +: CHUNK];
   assign w_y = b_q[int'(cnt_q)*CHUNK +: CHUNK];

   cla_slice #(
      .CHUNK (CHUNK)
   ) u_cla_slice (
      .x    (w_x),
      .y    (w_y),
      .cin  (cy_q),
      .s    (w_sum),
      .cout (w_cout)
   );

   always_comb begin
      w_res_full = res_q;
      w_res_full[int'(cnt_q)*CHUNK +: CHUNK] = w_sum;
      w_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_res_full[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
      if (w_ovf) begin
         w_res_sat = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end else begin
         w_res_sat = w_res_full;
      end
`else
      w_res_sat = w_res_full;
`endif
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      cy_d      = cy_q;
      ill_d     = ill_q;
      res_d     = res_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      zero_d    = zero_q;
      neg_d     = neg_q;
      illegal_d = illegal_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = (op == OP_SUB) ? ~b : b;
               cy_d    = (op == OP_SUB);
               ill_d   = (op != OP_ADD) && (op != OP_SUB);
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            res_d = w_res_full;
            cy_d  = w_cout;
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
               if (ill_q) begin
                  res_d     = '0;
                  carry_d   = 1'b0;
                  ovf_d     = 1'b0;
                  zero_d    = 1'b1;
                  neg_d     = 1'b0;
                  illegal_d = 1'b1;
               end else begin
                  res_d     = w_res_sat;
                  carry_d   = w_cout;
                  ovf_d     = w_ovf;
                  zero_d    = (w_res_sat == '0);
                  neg_d     = w_res_sat[WIDTH-1];
                  illegal_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         cy_q      <= 1'b0;
         ill_q     <= 1'b0;
         res_q     <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         zero_q    <= 1'b0;
         neg_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cy_q      <= cy_d;
         ill_q     <= ill_d;
         res_q     <= res_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         zero_q    <= zero_d;
         neg_q     <= neg_d;
         illegal_q <= illegal_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = res_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_seq.sv
// ============================================================================
// Module      : tb_addsub_seq
// Description : Self-checking bench for addsub_seq (WIDTH=32, CHUNK=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        carry;
   logic        ovf;
   logic        zero;
   logic        neg;
   logic        illegal;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   addsub_seq #(
      .WIDTH (32),
      .CHUNK (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg),
      .illegal   (illegal)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: true signed/unsigned arithmetic on wide integers.
   task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mop,
                        output logic [31:0] er, output logic ec, output logic ev,
                        output logic ez, output logic en, output logic ei);
      longint sa, sb, tr;
      logic [32:0] u;
      ei = !(mop == 3'b010 || mop == 3'b110);
      er = '0; ec = 1'b0; ev = 1'b0; ez = 1'b1; en = 1'b0;
      if (!ei) begin
         sa = longint'($signed(ma));
         sb = longint'($signed(mb));
         if (mop == 3'b010) begin
            u  = {1'b0, ma} + {1'b0, mb};
            ec = u[32];
            tr = sa + sb;
         end else begin
            ec = (ma >= mb);  // no borrow
            u  = {1'b0, ma - mb};
            tr = sa - sb;
         end
         er = u[31:0];
         ev = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
`ifdef ADDSUB_SAT_EN
         if (ev) er = (tr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
         ez = (er == 32'h0);
         en = er[31];
      end
   endtask

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] top,
                         input int hold);
      logic [31:0] er;
      logic ec, ev, ez, en, ei;
      int lat;
      model(ta, tb_v, top, er, ec, ev, ez, en, ei);
      lat = 0;
      while (!in_ready && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("ready_before_accept", in_ready, 1);
      a = ta; b = tb_v; op = top; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("latency", lat, 4);
      check_eq("result", result, er);
      check_eq("carry", carry, ec);
      check_eq("ovf", ovf, ev);
      check_eq("zero", zero, ez);
      check_eq("neg", neg, en);
      check_eq("illegal", illegal, ei);
      check_eq("in_ready_done", in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         @(posedge clk); #1;
         check_eq("bp_valid", out_valid, 1);
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_result", result, er);
         check_eq("bp_flags", {carry, ovf, zero, neg, illegal}, {ec, ev, ez, en, ei});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("post_hs_valid", out_valid, 0);
      check_eq("post_hs_ready", in_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic seen;
      int   sel;
      logic [2:0] rop;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_result", result, 0);
      check_eq("rst_flags", {carry, ovf, zero, neg, illegal}, 5'b0);

      run_op(32'h0000_0001, 32'hFFFF_FFFF, 3'b010, 0);
      run_op(32'd5, 32'd7, 3'b110, 1);
      run_op(32'h7FFF_FFFF, 32'd1, 3'b010, 0);
      run_op(32'h8000_0000, 32'd1, 3'b110, 0);
      run_op(32'h1234_5678, 32'hDEAD_BEEF, 3'b010, 3);
      run_op(32'h1234_5678, 32'h0, 3'b000, 0);
      run_op(32'h0000_0009, 32'h0000_0009, 3'b110, 0);

      // Abort in RUN: rst lands on the edge that would process slice 2.
      a = 32'hAAAA_5555; b = 32'h1111_2222; op = 3'b010; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort_out_valid", out_valid, 0);
      check_eq("abort_result", result, 0);
      check_eq("abort_in_ready", in_ready, 1);
      seen = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      out_ready = 1'b0;
      check_eq("abort_no_output", seen, 0);

      for (int t = 0; t < 24; t++) begin
         sel = $urandom_range(0, 3);
         rop = (sel < 2) ? 3'b010 : (sel == 2) ? 3'b110 : 3'($urandom);
         run_op($urandom, $urandom, rop, $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
